// File: rtl/display_timings_480p.sv
// display_timings_480p
//   Pixel-clock timing generator for a VGA-style raster, 640x480 by default.
//   It produces the beam position and the sync, data-enable and start-of-line /
//   start-of-frame strobes. Every output comes from a flop, and all outputs in a
//   given cycle describe the same sx/sy.
//
//   Generation only runs while the pixel clock is reported locked. Dropping lock
//   or asserting rst returns the block to an idle state. A later lock always
//   starts a fresh frame at (0,0).
//
// Ports
//   clk_pix    in   1      pixel clock
//   rst        in   1      asynchronous, active-high reset
//   clk_locked in   1      pixel clock locked (synchronous to clk_pix)
//   sx         out  CORDW  horizontal position
//   sy         out  CORDW  vertical position
//   hsync      out  1      horizontal sync (active level H_POL)
//   vsync      out  1      vertical sync (active level V_POL)
//   de         out  1      data enable, high inside the visible area
//   line       out  1      one-cycle pulse when sx == 0
//   frame      out  1      one-cycle pulse when sx == 0 and sy == 0
module display_timings_480p #(
  parameter int   CORDW  = 10,
  parameter int   H_RES  = 640,
  parameter int   H_FP   = 16,
  parameter int   H_SYNC = 96,
  parameter int   H_BP   = 48,
  parameter int   V_RES  = 480,
  parameter int   V_FP   = 10,
  parameter int   V_SYNC = 2,
  parameter int   V_BP   = 33,
  parameter logic H_POL  = 1'b0,
  parameter logic V_POL  = 1'b0
) (
  input  logic             clk_pix,
  input  logic             rst,
  input  logic             clk_locked,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line,
  output logic             frame
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] H_LAST       = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST       = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_VIS        = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_VIS        = CORDW'(V_RES);
  localparam logic [CORDW-1:0] H_SYNC_START = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] H_SYNC_END   = CORDW'(H_RES + H_FP + H_SYNC - 1);
  localparam logic [CORDW-1:0] V_SYNC_START = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] V_SYNC_END   = CORDW'(V_RES + V_FP + V_SYNC - 1);

  logic             running_q, running_d;
  logic [CORDW-1:0] sx_q, sx_d;
  logic [CORDW-1:0] sy_q, sy_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic             line_q, line_d;
  logic             frame_q, frame_d;

  // Next position. The output strobes are decoded from the *next* position so
  // that, once registered, they line up with the registered sx/sy rather than
  // trailing them by a cycle.
  always_comb begin
    running_d = running_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    if (!clk_locked) begin
      running_d = 1'b0;
      sx_d      = '0;
      sy_d      = '0;
    end else if (!running_q) begin
      // A fresh lock always begins at the top-left corner of a new frame.
      running_d = 1'b1;
      sx_d      = '0;
      sy_d      = '0;
    end else if (sx_q == H_LAST) begin
      sx_d = '0;
      sy_d = (sy_q == V_LAST) ? '0 : sy_q + 1'b1;
    end else begin
      sx_d = sx_q + 1'b1;
    end
  end

  // Decode the strobes for the next position. While idle the position is forced
  // to zero, so line/frame/de must also be gated by running_d.
  always_comb begin
    hsync_d = (running_d && sx_d >= H_SYNC_START && sx_d <= H_SYNC_END) ? H_POL : ~H_POL;
    vsync_d = (running_d && sy_d >= V_SYNC_START && sy_d <= V_SYNC_END) ? V_POL : ~V_POL;
    de_d    = running_d && (sx_d < H_VIS) && (sy_d < V_VIS);
    line_d  = running_d && (sx_d == '0);
    frame_d = running_d && (sx_d == '0) && (sy_d == '0);
  end

  // The asynchronous reset forces the idle values onto the outputs immediately,
  // without waiting for a pixel clock edge.
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      running_q <= 1'b0;
      sx_q      <= '0;
      sy_q      <= '0;
      hsync_q   <= ~H_POL;
      vsync_q   <= ~V_POL;
      de_q      <= 1'b0;
      line_q    <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      running_q <= running_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      de_q      <= de_d;
      line_q    <= line_d;
      frame_q   <= frame_d;
    end
  end

  assign sx    = sx_q;
  assign sy    = sy_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign de    = de_q;
  assign line  = line_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_display_timings_480p.sv
// tb_display_timings_480p
//   Drives two instances from the same clock, reset and lock inputs.
//   - d0 uses the default 640x480 timing with active-low syncs.
//   - d1 uses a shrunken raster (30x15 total) with active-high syncs, so that
//     frame wrap, vsync and frame spacing can be seen in a short run.
//   Every cycle, each instance is compared with a reference model. The model
//   reduces the raster to one count of cycles since the last start and derives
//   sx/sy and the strobes from that count with plain division and modulo.
module tb_display_timings_480p;

  localparam int CW = 10;

  localparam int S_HRES = 16, S_HFP = 4, S_HSYNC = 6, S_HBP = 4;
  localparam int S_VRES = 8,  S_VFP = 2, S_VSYNC = 2, S_VBP = 3;
  localparam int S_HT   = S_HRES + S_HFP + S_HSYNC + S_HBP;
  localparam int S_VT   = S_VRES + S_VFP + S_VSYNC + S_VBP;

  logic          clk_pix = 1'b0;
  logic          rst;
  logic          clk_locked;
  logic [CW-1:0] sx0, sy0, sx1, sy1;
  logic          hsync0, vsync0, de0, line0, frame0;
  logic          hsync1, vsync1, de1, line1, frame1;

  int  pass_count  = 0;
  int  check_count = 0;
  bit  m_run       = 1'b0;
  int  m_p         = 0;
  int  cyc         = 0;

  typedef struct {
    int sx, sy, hs, vs, de, line, frame;
  } exp_t;

  display_timings_480p d0 (
    .clk_pix(clk_pix), .rst(rst), .clk_locked(clk_locked),
    .sx(sx0), .sy(sy0), .hsync(hsync0), .vsync(vsync0),
    .de(de0), .line(line0), .frame(frame0)
  );

  display_timings_480p #(
    .CORDW(CW), .H_RES(S_HRES), .H_FP(S_HFP), .H_SYNC(S_HSYNC), .H_BP(S_HBP),
    .V_RES(S_VRES), .V_FP(S_VFP), .V_SYNC(S_VSYNC), .V_BP(S_VBP),
    .H_POL(1'b1), .V_POL(1'b1)
  ) d1 (
    .clk_pix(clk_pix), .rst(rst), .clk_locked(clk_locked),
    .sx(sx1), .sy(sy1), .hsync(hsync1), .vsync(vsync1),
    .de(de1), .line(line1), .frame(frame1)
  );

  always #5 clk_pix = ~clk_pix;

  // Expected outputs after p cycles of uninterrupted running.
  function automatic exp_t model(input bit run, input int p,
                                 input int hres, input int hfp, input int hsw, input int hbp,
                                 input int vres, input int vfp, input int vsw, input int vbp,
                                 input int hpol, input int vpol);
    exp_t e;
    int ht, vt;
    ht = hres + hfp + hsw + hbp;
    vt = vres + vfp + vsw + vbp;
    if (!run) begin
      e.sx = 0; e.sy = 0; e.hs = 1 - hpol; e.vs = 1 - vpol;
      e.de = 0; e.line = 0; e.frame = 0;
    end else begin
      e.sx    = p % ht;
      e.sy    = (p / ht) % vt;
      e.hs    = (e.sx >= hres + hfp && e.sx < hres + hfp + hsw) ? hpol : 1 - hpol;
      e.vs    = (e.sy >= vres + vfp && e.sy < vres + vfp + vsw) ? vpol : 1 - vpol;
      e.de    = (e.sx < hres && e.sy < vres) ? 1 : 0;
      e.line  = (e.sx == 0) ? 1 : 0;
      e.frame = (e.sx == 0 && e.sy == 0) ? 1 : 0;
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("[TB] FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
  endtask

  task automatic checkAll(input string phase);
    exp_t e0, e1;
    e0 = model(m_run, m_p, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0);
    e1 = model(m_run, m_p, S_HRES, S_HFP, S_HSYNC, S_HBP, S_VRES, S_VFP, S_VSYNC, S_VBP, 1, 1);
    checkOutput({phase, " d0.sx"},    32'(sx0),    e0.sx);
    checkOutput({phase, " d0.sy"},    32'(sy0),    e0.sy);
    checkOutput({phase, " d0.hsync"}, 32'(hsync0), e0.hs);
    checkOutput({phase, " d0.vsync"}, 32'(vsync0), e0.vs);
    checkOutput({phase, " d0.de"},    32'(de0),    e0.de);
    checkOutput({phase, " d0.line"},  32'(line0),  e0.line);
    checkOutput({phase, " d0.frame"}, 32'(frame0), e0.frame);
    checkOutput({phase, " d1.sx"},    32'(sx1),    e1.sx);
    checkOutput({phase, " d1.sy"},    32'(sy1),    e1.sy);
    checkOutput({phase, " d1.hsync"}, 32'(hsync1), e1.hs);
    checkOutput({phase, " d1.vsync"}, 32'(vsync1), e1.vs);
    checkOutput({phase, " d1.de"},    32'(de1),    e1.de);
    checkOutput({phase, " d1.line"},  32'(line1),  e1.line);
    checkOutput({phase, " d1.frame"}, 32'(frame1), e1.frame);
  endtask

  // Reset acts on the model at once because it is asynchronous in the design.
  task automatic applyStimulus(input bit lock, input bit reset);
    clk_locked = lock;
    rst        = reset;
    if (reset) m_run = 1'b0;
  endtask

  // One pixel clock edge: advance the model on the values sampled at the edge,
  // then check the outputs shortly after the edge.
  task automatic tick(input string phase);
    @(posedge clk_pix);
    cyc++;
    if (rst || !clk_locked) m_run = 1'b0;
    else if (!m_run) begin
      m_run = 1'b1;
      m_p   = 0;
    end else m_p++;
    #1;
    checkAll(phase);
  endtask

  // Pulse rst entirely between two clock edges, checking the idle values
  // before the next edge arrives.
  task automatic resetPulse(input bit lock);
    #2;
    applyStimulus(lock, 1'b1);
    #1;
    checkAll("async_rst");
    #1;
    applyStimulus(lock, 1'b0);
  endtask

  initial begin
    int last_line, last_frame, exp_frames, seen_frames;

    // Reset state with lock already present.
    applyStimulus(1'b1, 1'b1);
    #2;
    checkAll("reset");
    tick("reset_hold");
    tick("reset_hold");
    applyStimulus(1'b1, 1'b0);

    // First edge after release starts at (0,0). Check the line period on d0
    // across two lines, which covers the de window and the hsync window.
    last_line = -1;
    for (int i = 0; i < 1700; i++) begin
      tick("startup");
      if (line0 === 1'b1) begin
        if (last_line >= 0) checkOutput("d0.line_period", 32'(cyc - last_line), 800);
        last_line = cyc;
      end
    end

    // Several d1 frames: frame spacing and the number of frame pulses.
    last_frame  = -1;
    exp_frames  = 0;
    seen_frames = 0;
    for (int i = 0; i < 1000; i++) begin
      tick("frames");
      if (m_run && (m_p % (S_HT * S_VT)) == 0) exp_frames++;
      if (frame1 === 1'b1) begin
        seen_frames++;
        if (last_frame >= 0) checkOutput("d1.frame_period", 32'(cyc - last_frame), S_HT * S_VT);
        last_frame = cyc;
      end
    end
    checkOutput("d1.frame_count", 32'(seen_frames), 32'(exp_frames));

    // Loss of lock mid-frame, then relock for a single edge.
    applyStimulus(1'b0, 1'b0);
    tick("unlock");
    applyStimulus(1'b1, 1'b0);
    tick("relock");
    checkOutput("relock d0.frame", 32'(frame0), 1);
    for (int i = 0; i < 333; i++) tick("run");

    // Loss of lock lasting three edges.
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick("unlock3");
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 517; i++) tick("run");

    // Reset mid-frame between edges, with no resume afterwards.
    resetPulse(1'b1);
    for (int i = 0; i < 40; i++) tick("after_rst");

    // Random lock drops and reset pulses.
    for (int i = 0; i < 25000; i++) begin
      applyStimulus(($urandom_range(0, 399) != 0), 1'b0);
      tick("random");
      if ($urandom_range(0, 1999) == 0) resetPulse(clk_locked);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
